// File: rtl/queue_enq_arbiter_pkg.sv
// Shared CPU types for arbiters sitting in front of shared queues.
package queue_enq_arbiter_pkg;

    typedef enum logic {ARB_RUN, ARB_FLUSH} arb_state_t;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/queue_enq_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module queue_enq_arbiter_rr_pick
    import queue_enq_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] index,
    output logic          any
);

    always_comb begin
        int unsigned idx;
        logic [PW-1:0] sel;
        idx   = 0;
        sel   = '0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!any && valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                index      = sel;
            end
        end
    end

endmodule

// File: rtl/queue_enq_arbiter.sv
// Round-robin enqueue arbiter and credit tracker in front of a shared circular queue.
module queue_enq_arbiter
    import queue_enq_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1),
    parameter int unsigned PW    = ptr_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_grant,
    input  logic                   cons_ready,
    input  logic                   flush,
    output logic                   q_enq,
    output logic                   q_deq,
    output logic [WIDTH-1:0]       q_in,
    input  logic [WIDTH-1:0]       q_out,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CW-1:0]          count,
    output logic                   busy
);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          deq_q;

    logic [N_REQ-1:0] pick_grant;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    queue_enq_arbiter_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_grant = '0;
        q_enq     = 1'b0;
        q_deq     = 1'b0;
        q_in      = '0;
        if (!rst) begin
            case (state_q)
                ARB_RUN: begin
                    if (flush) begin
                        state_d = ARB_FLUSH;
                    end else begin
                        // Full blocks grants even if a deq frees a slot this cycle.
                        if (pick_any && count_q != CW'(DEPTH)) begin
                            req_grant = pick_grant;
                            q_enq     = 1'b1;
                            q_in      = req_data[pick_idx*WIDTH +: WIDTH];
                            rr_ptr_d  = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        end
                        q_deq = cons_ready && (count_q != '0);
                    end
                end
                ARB_FLUSH: begin
                    q_deq = (count_q != '0);
                    if (count_q == '0) state_d = ARB_RUN;
                end
                default: state_d = ARB_RUN;
            endcase
        end
        count_d = count_q + CW'(q_enq) - CW'(q_deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_RUN;
            count_q  <= '0;
            rr_ptr_q <= '0;
            deq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            // Entries drained by a flush are never presented to the consumer.
            deq_q    <= q_deq && (state_q == ARB_RUN);
        end
    end

    assign out_valid = deq_q;
    assign out_data  = q_out;
    assign count     = count_q;
    assign busy      = (state_q == ARB_FLUSH);

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed bench for queue_enq_arbiter with a behavioural circular queue attached.
module tb_queue_enq_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_grant;
    logic                   cons_ready;
    logic                   flush;
    logic                   q_enq;
    logic                   q_deq;
    logic [WIDTH-1:0]       q_in;
    logic [WIDTH-1:0]       q_out;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [CW-1:0]          count;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    queue_enq_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_grant  (req_grant),
        .cons_ready (cons_ready),
        .flush      (flush),
        .q_enq      (q_enq),
        .q_deq      (q_deq),
        .q_in       (q_in),
        .q_out      (q_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .count      (count),
        .busy       (busy)
    );

    // Behavioural queue: registered output, shares rst.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]       head, tail;
    always @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            q_out <= '0;
        end else begin
            if (q_enq) begin
                mem[tail] <= q_in;
                tail      <= tail + 3'd1;
            end
            if (q_deq) begin
                q_out <= mem[head];
                head  <= head + 3'd1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b1111;
        cons_ready = 1'b1;
        flush      = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = 32'h100 + i;

        // 1. Reset
        tick();
        tick();
        settle();
        check_val("rst_count", count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_grant", req_grant, 0);
        check_val("rst_deq", q_deq, 0);
        rst        = 1'b0;
        cons_ready = 1'b0;

        // 2. All producers valid, fill to DEPTH
        for (int i = 0; i < 8; i++) begin
            settle();
            check_val($sformatf("fill_grant%0d", i), req_grant, 64'(4'b0001 << (i % 4)));
            check_val($sformatf("fill_qin%0d", i), q_in, 64'(32'h100 + (i % 4)));
            tick();
        end
        settle();
        check_val("full_count", count, 8);
        check_val("full_grant", req_grant, 0);
        check_val("full_enq", q_enq, 0);

        // Drain and verify FIFO order through out_data
        req_valid  = '0;
        cons_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            check_val($sformatf("drain_deq%0d", k), q_deq, 1);
            tick();
            check_val($sformatf("drain_ov%0d", k), out_valid, 1);
            check_val($sformatf("drain_data%0d", k), out_data, 64'(32'h100 + (k % 4)));
            check_val($sformatf("drain_count%0d", k), count, 64'(7 - k));
        end
        settle();
        check_val("empty_deq", q_deq, 0);
        cons_ready = 1'b0;
        tick();
        check_val("empty_ov", out_valid, 0);

        // 3. rr_ptr=2 then req_valid=1010: 3, 1, 3
        req_valid = 4'b0010;
        settle();
        check_val("rr_setup", req_grant, 4'b0010);
        tick();
        req_valid = 4'b1010;
        settle();
        check_val("rr_g0", req_grant, 4'b1000);
        tick();
        settle();
        check_val("rr_g1", req_grant, 4'b0010);
        tick();
        settle();
        check_val("rr_g2", req_grant, 4'b1000);
        tick();
        req_valid  = '0;
        cons_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        cons_ready = 1'b0;
        tick();
        check_val("rr_drained", count, 0);

        // 4. Enq 0xA, 0xB then two dequeues
        req_data[0 +: WIDTH] = 32'hA;
        req_valid = 4'b0001;
        tick();
        req_data[0 +: WIDTH] = 32'hB;
        tick();
        req_valid  = '0;
        cons_ready = 1'b1;
        settle();
        check_val("ab_count2", count, 2);
        check_val("ab_deq0", q_deq, 1);
        tick();
        check_val("ab_ov0", out_valid, 1);
        check_val("ab_data0", out_data, 32'hA);
        check_val("ab_count1", count, 1);
        tick();
        check_val("ab_ov1", out_valid, 1);
        check_val("ab_data1", out_data, 32'hB);
        check_val("ab_count0", count, 0);
        cons_ready = 1'b0;
        settle();
        check_val("ab_deq_idle", q_deq, 0);
        tick();
        check_val("ab_ov_idle", out_valid, 0);

        // 5. Full with simultaneous deq demand: deq only, then grant resumes
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        cons_ready = 1'b1;
        settle();
        check_val("full_deq_count", count, 8);
        check_val("full_deq_grant", req_grant, 0);
        check_val("full_deq_deq", q_deq, 1);
        tick();
        check_val("full_deq_count7", count, 7);
        settle();
        check_val("resume_enq", q_enq, 1);
        check_val("resume_deq", q_deq, 1);
        tick();
        check_val("resume_count", count, 7);
        req_valid = '0;
        tick();
        tick();
        cons_ready = 1'b0;
        tick();
        check_val("pre_flush_count", count, 5);

        // 6. Flush with 5 entries
        req_valid = 4'b1111;
        flush     = 1'b1;
        settle();
        check_val("fl_idle_grant", req_grant, 0);
        check_val("fl_idle_deq", q_deq, 0);
        check_val("fl_idle_busy", busy, 0);
        tick();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) flush = 1'b1;
            if (k == 3) flush = 1'b0;
            settle();
            check_val($sformatf("fl_busy%0d", k), busy, 1);
            check_val($sformatf("fl_deq%0d", k), q_deq, 1);
            check_val($sformatf("fl_grant%0d", k), req_grant, 0);
            check_val($sformatf("fl_ov%0d", k), out_valid, 0);
            tick();
        end
        req_valid = '0;
        settle();
        check_val("fl_last_busy", busy, 1);
        check_val("fl_last_deq", q_deq, 0);
        check_val("fl_last_count", count, 0);
        tick();
        check_val("fl_done_busy", busy, 0);
        check_val("fl_done_count", count, 0);
        check_val("fl_done_ov", out_valid, 0);

        // Flush interrupted by reset at drain cycle 2
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        req_valid = '0;
        check_val("flr_count", count, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        check_val("flr_rst_deq", q_deq, 0);
        tick();
        rst = 1'b0;
        settle();
        check_val("flr_busy", busy, 0);
        check_val("flr_count0", count, 0);
        check_val("flr_ov", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
